// File: rtl/button_hue_reader.sv
// Debounced active-low push button with short/long press classification and a wrapping hue index.
// Optional AUTO_REPEAT_EN: while long-held, hue_index auto-advances every REPEAT_CYCLES with repeat_pulse.
module button_hue_reader #(
    parameter int CLOCK_FREQ      = 12_000_000,
    parameter int DEBOUNCE_CYCLES = CLOCK_FREQ / 100,
    parameter int LONG_CYCLES     = CLOCK_FREQ,
    parameter int REPEAT_CYCLES   = CLOCK_FREQ / 4,
    parameter int NUM_HUES        = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       BTN_N,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic [2:0] hue_index
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = $clog2(LONG_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [2:0]        HUE_LAST  = 3'(NUM_HUES - 1);

    localparam logic [2:0] S_RELEASED   = 3'd0;
    localparam logic [2:0] S_PRESS_DB   = 3'd1;
    localparam logic [2:0] S_HELD       = 3'd2;
    localparam logic [2:0] S_LONG_HELD  = 3'd3;
    localparam logic [2:0] S_RELEASE_DB = 3'd4;

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 2 || REPEAT_CYCLES < 1 ||
        NUM_HUES < 2 || NUM_HUES > 8) begin : g_bad_params
        $error("button_hue_reader: parameter out of range");
    end

    logic              sync1;
    logic              sync;
    logic [2:0]        state;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              long_done;

    function automatic logic [2:0] next_hue(input logic [2:0] h);
        return (h == HUE_LAST) ? 3'd0 : h + 3'd1;
    endfunction

    // Flops reset to 1 so the button reads as released straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync  <= 1'b1;
        end else begin
            sync1 <= BTN_N;
            sync  <= sync1;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep_cnt;
`else
    assign repeat_pulse = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_RELEASED;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            long_done     <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            hue_index     <= '0;
`ifdef AUTO_REPEAT_EN
            rep_cnt       <= '0;
            repeat_pulse  <= 1'b0;
`endif
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
`ifdef AUTO_REPEAT_EN
            repeat_pulse  <= 1'b0;
`endif
            case (state)
                S_RELEASED: begin
                    if (!sync) begin
                        state  <= S_PRESS_DB;
                        db_cnt <= '0;
                    end
                end
                S_PRESS_DB: begin
                    if (sync) begin
                        state <= S_RELEASED;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= S_HELD;
                        press_pulse <= 1'b1;
                        btn_level   <= 1'b1;
                        hold_cnt    <= '0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                S_HELD: begin
                    if (sync) begin
                        state  <= S_RELEASE_DB;
                        db_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state      <= S_LONG_HELD;
                        long_pulse <= 1'b1;
                        long_done  <= 1'b1;
                        hue_index  <= '0;
`ifdef AUTO_REPEAT_EN
                        rep_cnt    <= '0;
`endif
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                S_LONG_HELD: begin
                    if (sync) begin
                        state  <= S_RELEASE_DB;
                        db_cnt <= '0;
                    end
`ifdef AUTO_REPEAT_EN
                    else if (rep_cnt == REP_LAST) begin
                        repeat_pulse <= 1'b1;
                        hue_index    <= next_hue(hue_index);
                        rep_cnt      <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + REP_W'(1);
                    end
`endif
                end
                S_RELEASE_DB: begin
                    // A bounce resumes the hold with hold_cnt/rep_cnt untouched.
                    if (!sync) begin
                        state <= long_done ? S_LONG_HELD : S_HELD;
                    end else if (db_cnt == DB_LAST) begin
                        state         <= S_RELEASED;
                        release_pulse <= 1'b1;
                        btn_level     <= 1'b0;
                        long_done     <= 1'b0;
`ifdef AUTO_REPEAT_EN
                        rep_cnt       <= '0;
`endif
                        if (!long_done) begin
                            short_pulse <= 1'b1;
                            hue_index   <= next_hue(hue_index);
                        end
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                default: state <= S_RELEASED;
            endcase
        end
    end

endmodule

// File: doc/button_hue_reader.md
Name: button_hue_reader

Overview:
- Input-side counterpart to the board's LED/RGB output drivers. Reads one active-low push button, synchronises it to clk and debounces it.
- Classifies each debounced press as short or long and emits one-cycle event pulses.
- Maintains a hue_index (0..NUM_HUES-1) that downstream RGB mapping logic consumes: a short press advances it, a long press returns it to 0.

Parameters:
- CLOCK_FREQ, 12_000_000, clk frequency in Hz (informational; used for default derivation).
- DEBOUNCE_CYCLES, 120_000, consecutive stable cycles required to accept an edge (10 ms); must be >=1.
- LONG_CYCLES, 12_000_000, hold duration counted from press acceptance that makes a press long (1 s); must be >=2.
- REPEAT_CYCLES, 3_000_000, auto-repeat interval once long-held (used only with AUTO_REPEAT_EN).
- NUM_HUES, 6, hue count; hue_index wraps NUM_HUES-1 -> 0; range 2..8.

Ports:
- clk  input  1  system clock, 12 MHz
- rst_n  input  1  asynchronous active-low reset
- BTN_N  input  1  raw button pin, active low (0 = pressed), asynchronous to clk
- btn_level  output  1  debounced state, 1 = pressed
- press_pulse  output  1  one-cycle pulse on accepted press
- release_pulse  output  1  one-cycle pulse on accepted release
- short_pulse  output  1  one-cycle pulse on release of a press that never reached long
- long_pulse  output  1  one-cycle pulse when a hold reaches LONG_CYCLES
- repeat_pulse  output  1  one-cycle auto-repeat pulse (tied 0 without AUTO_REPEAT_EN)
- hue_index  output  3  current hue, 0..NUM_HUES-1

Behaviour:
- Reset: one clock; rst_n is asynchronous and active-low. While rst_n=0, both synchroniser flops = 1 (released), state = RELEASED, all counters = 0, all outputs = 0, hue_index = 0. Deassertion is taken on the next clk edge.
- Synchroniser: 2-flop chain on BTN_N. sync is the second flop. All logic below uses sync only.
- All outputs are registered. Pulses are exactly one cycle wide.
- The FSM has five states. db_cnt and hold_cnt are sized with $clog2 of their limits. The long_done flag is cleared on entry to RELEASED.
- RELEASED: on sync=0, go to PRESS_DB and set db_cnt=0.
- PRESS_DB:
  - sync=1 (bounce): return to RELEASED; no pulse.
  - Otherwise, if db_cnt==DEBOUNCE_CYCLES-1: go to HELD; press_pulse=1, btn_level<=1, hold_cnt=0.
  - Otherwise: db_cnt++.
- Press latency: counting the first edge that samples BTN_N=0 as edge 1, press_pulse is high after edge DEBOUNCE_CYCLES+3.
- HELD:
  - sync=1: go to RELEASE_DB with db_cnt=0. Release has priority over the long threshold in the same cycle.
  - Otherwise, if hold_cnt==LONG_CYCLES-1: go to LONG_HELD; long_pulse=1, long_done=1, hue_index<=0.
  - Otherwise: hold_cnt++.
- LONG_HELD: on sync=1, go to RELEASE_DB with db_cnt=0.
- RELEASE_DB:
  - hold_cnt is frozen in this state.
  - sync=0 (bounce): return to LONG_HELD if long_done, else to HELD. No pulse; hold_cnt resumes from its frozen value.
  - Otherwise, if db_cnt==DEBOUNCE_CYCLES-1: go to RELEASED; release_pulse=1, btn_level<=0. If long_done=0, also short_pulse=1 and hue_index advances in the same cycle.
  - Otherwise: db_cnt++.
- hue advance: if hue_index==NUM_HUES-1 then 0, else +1. No other width growth.
- Reset mid-press: all state is discarded. A button still held after rst_n rises is treated as a new press and needs a full debounce.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - In LONG_HELD, rep_cnt counts from 0 on entry.
  - At rep_cnt==REPEAT_CYCLES-1, repeat_pulse=1, hue_index advances (with wrap) and rep_cnt=0.
  - rep_cnt freezes in RELEASE_DB and clears on exit to RELEASED.
  - No short_pulse is produced at release.
- Undefined: repeat_pulse is constant 0, no rep_cnt register exists, and LONG_HELD only waits for release.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5, NUM_HUES=6):
- rst_n=0 with BTN_N=0 -> all outputs 0 and hue_index=0; after release of reset, press_pulse first appears after edge 7.
- Clean press held 10 cycles, then release -> one press_pulse, then release_pulse and short_pulse in the same cycle, hue_index 0->1, btn_level high between the two pulses.
- BTN_N glitches low for 3 cycles, repeated 5 times -> no pulses, hue_index unchanged, btn_level stays 0.
- Six short presses from hue 0 -> hue sequence 1,2,3,4,5,0 (wrap).
- From hue 3, hold 30 cycles -> long_pulse once, hue_index=0; at release, release_pulse with no short_pulse.
- AUTO_REPEAT_EN defined, hold 40 cycles from hue 0 -> long_pulse (hue 0), then repeat_pulse every 5 cycles advancing hue 1,2,3,... until release begins. A 2-cycle release bounce freezes the repeat count without pulsing.
